// File: rtl/pipe_front_regs_if.sv
// Fetch/decode/execute pipeline-register bundle: the hazard controls, the
// operands entering ID, and the registered and forwarded values leaving toward EX.
interface pipe_front_regs_if #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  // hazard-unit controls
  logic              stallf;
  logic              stalld;
  logic              flushd;
  logic              flushe;
  logic [1:0]        fwae;
  logic [1:0]        fwbe;
  logic [1:0]        pcsrce;
  // datapath inputs
  logic [31:0]       pctargete;
  logic [31:0]       aluresulte;
  logic [31:0]       instrf;
  logic [31:0]       rd1d;
  logic [31:0]       rd2d;
  logic [31:0]       immextd;
  logic [CTRL_W-1:0] ctrld;
  logic [31:0]       resultw;
  logic [31:0]       aluresultm;
  // registered / forwarded outputs
  logic [31:0]       pcf;
  logic [31:0]       instrd;
  logic [31:0]       pcd;
  logic [4:0]        rs1d;
  logic [4:0]        rs2d;
  logic [4:0]        rs1e;
  logic [4:0]        rs2e;
  logic [4:0]        rde;
  logic [31:0]       pce;
  logic [31:0]       pcplus4e;
  logic [31:0]       immexte;
  logic [CTRL_W-1:0] ctrle;
  logic              valide;
  logic [31:0]       srcae;
  logic [31:0]       writedatae;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stallf, stalld, flushd, flushe, fwae, fwbe, pcsrce,
           pctargete, aluresulte, instrf, rd1d, rd2d, immextd, ctrld,
           resultw, aluresultm,
    input  pcf, instrd, pcd, rs1d, rs2d, rs1e, rs2e, rde, pce, pcplus4e,
           immexte, ctrle, valide, srcae, writedatae, stall_cnt, flush_cnt
  );

  modport slave (
    input  stallf, stalld, flushd, flushe, fwae, fwbe, pcsrce,
           pctargete, aluresulte, instrf, rd1d, rd2d, immextd, ctrld,
           resultw, aluresultm,
    output pcf, instrd, pcd, rs1d, rs2d, rs1e, rs2e, rde, pce, pcplus4e,
           immexte, ctrle, valide, srcae, writedatae, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers under hazard stall/flush control, one cycle per stage;
// forwarding muxes are combinational. Backpressure is stallf/stalld only; ID/EX never stalls.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CTRL_W    = 12,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_front_regs_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic [31:0]       pcplus4;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_JALR   = 2'b10;
  localparam logic [1:0] FWD_WB       = 2'b01;
  localparam logic [1:0] FWD_MEM      = 2'b10;

  logic [31:0]      pcf_q, pcf_d;
  logic [31:0]      instrd_q, instrd_d;
  logic [31:0]      pcd_q, pcd_d;
  idex_t            idex_q, idex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      srca, srcb;

  // Redirects come from a resolved branch/jump in EX, so they beat a fetch stall.
  always_comb begin
    pcf_d = pcf_q;
    case (bus.pcsrce)
      PCSEL_TARGET: pcf_d = bus.pctargete;
      PCSEL_JALR:   pcf_d = bus.aluresulte;
      default: begin
        if (!bus.stallf) pcf_d = pcf_q + 32'd4;
      end
    endcase
  end

  always_comb begin
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    if (bus.flushd) begin
      instrd_d = NOP_INSTR;
      pcd_d    = 32'd0;
    end else if (!bus.stalld) begin
      instrd_d = bus.instrf;
      pcd_d    = pcf_q;
    end
  end

  // ID/EX always advances; a flush turns the slot into an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (!bus.flushe) begin
      idex_d.valid   = (instrd_q != NOP_INSTR);
      idex_d.rs1     = instrd_q[19:15];
      idex_d.rs2     = instrd_q[24:20];
      idex_d.rd      = instrd_q[11:7];
      idex_d.rd1     = bus.rd1d;
      idex_d.rd2     = bus.rd2d;
      idex_d.imm     = bus.immextd;
      idex_d.pc      = pcd_q;
      idex_d.pcplus4 = pcd_q + 32'd4;
      idex_d.ctrl    = bus.ctrld;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.stalld && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (bus.flushe && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      instrd_q    <= NOP_INSTR;
      pcd_q       <= 32'd0;
      idex_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instrd_q    <= instrd_d;
      pcd_q       <= pcd_d;
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Select 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    case (bus.fwae)
      FWD_WB:  srca = bus.resultw;
      FWD_MEM: srca = bus.aluresultm;
      default: srca = idex_q.rd1;
    endcase
    case (bus.fwbe)
      FWD_WB:  srcb = bus.resultw;
      FWD_MEM: srcb = bus.aluresultm;
      default: srcb = idex_q.rd2;
    endcase
  end

  assign bus.pcf        = pcf_q;
  assign bus.instrd     = instrd_q;
  assign bus.pcd        = pcd_q;
  assign bus.rs1d       = instrd_q[19:15];
  assign bus.rs2d       = instrd_q[24:20];
  assign bus.rs1e       = idex_q.rs1;
  assign bus.rs2e       = idex_q.rs2;
  assign bus.rde        = idex_q.rd;
  assign bus.pce        = idex_q.pc;
  assign bus.pcplus4e   = idex_q.pcplus4;
  assign bus.immexte    = idex_q.imm;
  assign bus.ctrle      = idex_q.ctrl;
  assign bus.valide     = idex_q.valid;
  assign bus.srcae      = srca;
  assign bus.writedatae = srcb;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed-vector bench for pipe_front_regs with 4-bit counters so saturation
// is reachable; expected values are hand-computed per step.
module tb_pipe_front_regs;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pipe_front_regs_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipe_front_regs #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.stallf = 0; bus.stalld = 0; bus.flushd = 0; bus.flushe = 0;
    bus.fwae = 2'b00; bus.fwbe = 2'b00; bus.pcsrce = 2'b00;
    bus.pctargete = 32'h0; bus.aluresulte = 32'h0;
    bus.instrf = 32'h0050_0093;
    bus.rd1d = 32'h11; bus.rd2d = 32'h22; bus.immextd = 32'h5;
    bus.ctrld = 12'hABC; bus.resultw = 32'h0; bus.aluresultm = 32'h0;

    #1 rst = 1'b1;
    #1;
    check("rst_pcf",    bus.pcf, 32'h0);
    check("rst_instrd", bus.instrd, 32'h13);
    check("rst_pcd",    bus.pcd, 32'h0);
    check("rst_valide", {31'b0, bus.valide}, 32'h0);
    check("rst_ctrle",  {20'b0, bus.ctrle}, 32'h0);
    check("rst_rde",    {27'b0, bus.rde}, 32'h0);
    check("rst_pce",    bus.pce, 32'h0);
    check("rst_stall",  {28'b0, bus.stall_cnt}, 32'h0);
    check("rst_flush",  {28'b0, bus.flush_cnt}, 32'h0);
    #1 rst = 1'b0;

    // no-hazard flow
    tick();
    check("e1_pcf",    bus.pcf, 32'h4);
    check("e1_instrd", bus.instrd, 32'h0050_0093);
    check("e1_pcd",    bus.pcd, 32'h0);
    check("e1_rs2d",   {27'b0, bus.rs2d}, 32'h5);
    check("e1_valide", {31'b0, bus.valide}, 32'h0);
    tick();
    check("e2_pcf",    bus.pcf, 32'h8);
    check("e2_pcd",    bus.pcd, 32'h4);
    check("e2_rde",    {27'b0, bus.rde}, 32'h1);
    check("e2_rs1e",   {27'b0, bus.rs1e}, 32'h0);
    check("e2_rs2e",   {27'b0, bus.rs2e}, 32'h5);
    check("e2_valide", {31'b0, bus.valide}, 32'h1);
    check("e2_ctrle",  {20'b0, bus.ctrle}, 32'hABC);
    check("e2_pce",    bus.pce, 32'h0);
    check("e2_pc4e",   bus.pcplus4e, 32'h4);
    check("e2_imme",   bus.immexte, 32'h5);
    check("e2_srcae",  bus.srcae, 32'h11);
    tick();
    check("e3_pcf",    bus.pcf, 32'hC);
    check("e3_pce",    bus.pce, 32'h4);
    tick();
    check("e4_pcf",    bus.pcf, 32'h10);

    // load-use stall with EX bubble
    bus.stallf = 1; bus.stalld = 1; bus.flushe = 1;
    tick();
    check("lu_pcf",    bus.pcf, 32'h10);
    check("lu_instrd", bus.instrd, 32'h0050_0093);
    check("lu_pcd",    bus.pcd, 32'hC);
    check("lu_ctrle",  {20'b0, bus.ctrle}, 32'h0);
    check("lu_valide", {31'b0, bus.valide}, 32'h0);
    check("lu_stall",  {28'b0, bus.stall_cnt}, 32'h1);
    check("lu_flush",  {28'b0, bus.flush_cnt}, 32'h1);
    bus.stallf = 0; bus.stalld = 0; bus.flushe = 0;
    bus.rd1d = 32'h55;
    tick();
    check("lu2_pcf",    bus.pcf, 32'h14);
    check("lu2_pce",    bus.pce, 32'hC);
    check("lu2_pc4e",   bus.pcplus4e, 32'h10);
    check("lu2_srcae",  bus.srcae, 32'h55);
    check("lu2_valide", {31'b0, bus.valide}, 32'h1);

    // taken branch, then jalr
    bus.pcsrce = 2'b01; bus.pctargete = 32'h100; bus.flushd = 1; bus.flushe = 1;
    tick();
    check("br_pcf",    bus.pcf, 32'h100);
    check("br_instrd", bus.instrd, 32'h13);
    check("br_pcd",    bus.pcd, 32'h0);
    check("br_ctrle",  {20'b0, bus.ctrle}, 32'h0);
    check("br_valide", {31'b0, bus.valide}, 32'h0);
    check("br_flush",  {28'b0, bus.flush_cnt}, 32'h2);
    bus.pcsrce = 2'b00; bus.flushd = 0; bus.flushe = 0;
    tick();
    check("br2_pcf",    bus.pcf, 32'h104);
    check("br2_pcd",    bus.pcd, 32'h100);
    check("br2_valide", {31'b0, bus.valide}, 32'h0);
    bus.pcsrce = 2'b10; bus.aluresulte = 32'h204;
    tick();
    check("jalr_pcf",    bus.pcf, 32'h204);
    check("jalr_pce",    bus.pce, 32'h100);
    check("jalr_valide", {31'b0, bus.valide}, 32'h1);
    bus.pcsrce = 2'b11;
    tick();
    check("pcsel11_pcf", bus.pcf, 32'h208);
    bus.pcsrce = 2'b00;

    // forwarding sweep
    bus.rd1d = 32'h1; bus.rd2d = 32'h4; bus.resultw = 32'h2; bus.aluresultm = 32'h3;
    tick();
    for (int s = 0; s < 4; s++) begin
      logic [31:0] ea, eb;
      ea = (s == 1) ? 32'h2 : (s == 2) ? 32'h3 : 32'h1;
      eb = (s == 1) ? 32'h2 : (s == 2) ? 32'h3 : 32'h4;
      bus.fwae = s[1:0];
      bus.fwbe = s[1:0];
      #1;
      check($sformatf("fwa_%0d", s), bus.srcae, ea);
      check($sformatf("fwb_%0d", s), bus.writedatae, eb);
    end
    bus.fwae = 2'b00; bus.fwbe = 2'b00;

    // flush beats stall on IF/ID; redirect beats stall on PC
    bus.stalld = 1; bus.flushd = 1; bus.stallf = 1;
    bus.pcsrce = 2'b01; bus.pctargete = 32'h300;
    tick();
    check("sf_instrd", bus.instrd, 32'h13);
    check("sf_pcd",    bus.pcd, 32'h0);
    check("sf_pcf",    bus.pcf, 32'h300);
    check("sf_stall",  {28'b0, bus.stall_cnt}, 32'h2);
    bus.flushd = 0; bus.stallf = 0; bus.pcsrce = 2'b00;

    // saturation
    repeat (20) tick();
    check("sat_stall",  {28'b0, bus.stall_cnt}, 32'hF);
    tick();
    check("sat_hold",   {28'b0, bus.stall_cnt}, 32'hF);
    check("sat_flush",  {28'b0, bus.flush_cnt}, 32'h2);
    bus.stalld = 0;
    tick();

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_pcf",    bus.pcf, 32'h0);
    check("ar_instrd", bus.instrd, 32'h13);
    check("ar_valide", {31'b0, bus.valide}, 32'h0);
    check("ar_stall",  {28'b0, bus.stall_cnt}, 32'h0);
    check("ar_flush",  {28'b0, bus.flush_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_pcf",    bus.pcf, 32'h4);
    check("rel_instrd", bus.instrd, 32'h0050_0093);
    check("rel_pcd",    bus.pcd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Fetch/decode/execute pipeline-register block that consumes the hazard unit's stall, flush and forward controls.
- Holds the PC, the IF/ID register and the ID/EX register, and applies the stall/flush rules to them.
- Drives the EX-stage forwarding operand muxes and the rs/rd fields the hazard unit compares.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted on IF/ID reset or flush.
- CTRL_W, 12, width of the opaque decoded-control bundle carried ID->EX.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stallf  in  1  hold PC
- stalld  in  1  hold IF/ID
- flushd  in  1  clear IF/ID to NOP
- flushe  in  1  clear ID/EX to bubble
- fwae  in  2  SrcA select: 00 rd1e, 01 resultw, 10 aluresultm
- fwbe  in  2  SrcB select, same encoding
- pcsrce  in  2  next-PC select: 00 pcf+4, 01 pctargete, 10 aluresulte
- pctargete  in  32  branch/jal target
- aluresulte  in  32  jalr target
- instrf  in  32  instruction-memory read data for pcf
- rd1d  in  32  register-file read data for rs1d
- rd2d  in  32  register-file read data for rs2d
- immextd  in  32  sign-extended immediate for the instruction in ID
- ctrld  in  CTRL_W  decoded control for the instruction in ID
- resultw  in  32  WB result for forwarding
- aluresultm  in  32  MEM ALU result for forwarding
- pcf  out  32  fetch PC
- instrd  out  32  IF/ID instruction
- pcd  out  32  IF/ID PC
- rs1d  out  5  instrd[19:15]
- rs2d  out  5  instrd[24:20]
- rs1e  out  5  ID/EX rs1
- rs2e  out  5  ID/EX rs2
- rde  out  5  ID/EX rd
- pce  out  32  ID/EX PC
- pcplus4e  out  32  ID/EX PC+4
- immexte  out  32  ID/EX immediate
- ctrle  out  CTRL_W  ID/EX control
- valide  out  1  EX slot holds a real instruction
- srcae  out  32  forwarded operand A
- writedatae  out  32  forwarded operand B / store data
- stall_cnt  out  CNT_W  cycles with stalld=1
- flush_cnt  out  CNT_W  cycles with flushe=1

Behaviour:
- Reset (async, rst=1):
  - pcf=RESET_PC; instrd=NOP_INSTR; pcd=0.
  - All ID/EX fields=0; valide=0.
  - Both counters=0.
- PC register:
  - Priority: pcsrce!=00 loads pctargete (01) or aluresulte (10).
  - Else if stallf=1, hold.
  - Else pcf+4, 32-bit wrap.
  - pcsrce=11 is treated as 00.
  - Redirect wins over stallf.
- IF/ID register:
  - flushd=1: instrd=NOP_INSTR, pcd=0. Flush wins over stalld.
  - Else if stalld=1: hold.
  - Else load instrf and pcf.
- ID/EX register:
  - flushe=1: all fields 0, valide=0 (bubble: ctrle=0 means no reg/mem write).
  - Else load rs1d, rs2d, instrd[11:7], rd1d, rd2d, immextd, ctrld, pcd, pcd+4.
  - valide=1 unless instrd==NOP_INSTR.
  - The ID/EX register is never stalled.
- Forwarding muxes (combinational, zero latency):
  - srcae selects rd1e / resultw / aluresultm per fwae.
  - writedatae selects rd2e / resultw / aluresultm per fwbe.
  - Select 11 yields the register value (rd1e/rd2e).
- Counters:
  - stall_cnt increments each cycle stalld=1.
  - flush_cnt increments each cycle flushe=1.
  - Both saturate at all-ones with no wrap.
- Load-use case (stallf=stalld=flushe=1): PC and IF/ID hold one cycle while EX receives a bubble. The stalled instruction re-enters ID/EX the following cycle with fresh rd1d/rd2d.
- Taken branch (flushd=flushe=1, pcsrce!=00): two bubbles, with the target fetched next cycle.
- Reset asserted mid-operation clears state immediately, independent of clk.
- Release of reset takes effect at the next rising edge; first fetch is at RESET_PC.

Test Plan:
- Reset, then run 3 cycles with no hazards, instrf=0x00500093 -> pcf 0,4,8,C; instrd=0x00500093 one cycle after fetch; rs1e/rde follow one cycle later.
- Load-use: stallf=stalld=flushe=1 for one cycle at pcf=0x10 -> pcf stays 0x10, instrd holds, ctrle=0 and valide=0 next cycle, stall_cnt=1, flush_cnt=1.
- Branch: pcsrce=01, pctargete=0x100, flushd=flushe=1 -> next cycle pcf=0x100, instrd=0x00000013, ctrle=0; jalr with pcsrce=10, aluresulte=0x204 -> pcf=0x204.
- Forwarding: rd1e=1, resultw=2, aluresultm=3; fwae sweep 00/01/10/11 -> srcae=1/2/3/1; same sweep on fwbe for writedatae.
- Simultaneous stalld=1 and flushd=1 -> instrd=NOP_INSTR. Simultaneous stallf=1 and pcsrce=01 -> pcf=pctargete.
- Counter saturation with CNT_W=4: hold stalld=1 for 20 cycles -> stall_cnt reaches 15 and stays. rst pulse mid-clock -> pcf=RESET_PC immediately, counters=0.
